// File: rtl/friscv_pmp_encoder.sv
// -----------------------------------------------------------------------------
// friscv_pmp_encoder
//
// Programs one PMP entry from a (base, log2 size, permissions, lock) request.
// The target entry is first disabled (its cfg byte cleared), then its pmpaddr
// is written, then the cfg byte is written with the new A/permission/lock
// bits. This ordering guarantees the region never matches while its address
// is half-updated. The other three bytes of the shared cfg CSR are preserved
// exactly as read back during the check phase.
//
// Ports:
//   aclk, srst           clock, synchronous active-high reset
//   req_*                request channel (valid/ready), fields captured on accept
//   csr_rd_addr/data     combinational CSR read port (data valid same cycle)
//   csr_wr_*             CSR write port (valid/ready), addr/data held until ready
//   rsp_valid/ready      completion handshake
//   rsp_error            0 ok, 1 illegal geometry or index, 2 entry locked
// -----------------------------------------------------------------------------
module friscv_pmp_encoder #(
    parameter int XLEN      = 32,
    parameter int RLEN      = 34,
    parameter int NB_REGION = 16
) (
    input  logic            aclk,
    input  logic            srst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [3:0]      req_index,
    input  logic [RLEN-1:0] req_base,
    input  logic [5:0]      req_log2size,
    input  logic [2:0]      req_perm,
    input  logic            req_lock,
    output logic [11:0]     csr_rd_addr,
    input  logic [XLEN-1:0] csr_rd_data,
    output logic            csr_wr_valid,
    input  logic            csr_wr_ready,
    output logic [11:0]     csr_wr_addr,
    output logic [XLEN-1:0] csr_wr_data,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [1:0]      rsp_error
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        WR_DIS,
        WR_ADDR,
        WR_CFG,
        RESP
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [3:0]      r_index;
    logic [RLEN-1:0] r_base;
    logic [5:0]      r_log2size;
    logic [2:0]      r_perm;
    logic            r_lock;
    logic [XLEN-1:0] r_old_cfg;
    logic [1:0]      r_error;

    logic [11:0]     w_cfg_csr;
    logic [11:0]     w_addr_csr;
    logic [4:0]      w_shift;
    logic [RLEN-1:0] w_size_mask;
    logic [RLEN-1:0] w_napot_mask;
    logic            w_geom_err;
    logic            w_lock_err;
    logic [1:0]      w_check_err;
    logic [7:0]      w_new_byte;
    logic [XLEN-1:0] w_cfg_dis;
    logic [XLEN-1:0] w_cfg_new;
    logic [XLEN-1:0] w_addr_data;

    // CSR addressing: four entries share one cfg CSR, one byte each
    assign w_cfg_csr  = 12'h3A0 + {10'b0, r_index[3:2]};
    assign w_addr_csr = 12'h3B0 + {8'b0, r_index};
    assign w_shift    = {r_index[1:0], 3'b000};

    // Shifts at RLEN width: a shift of RLEN or more yields zero, so the
    // mask becomes all ones, which is the correct full-range mask.
    assign w_size_mask  = (RLEN'(1) << r_log2size) - RLEN'(1);
    assign w_napot_mask = (RLEN'(1) << (r_log2size - 6'd3)) - RLEN'(1);

    assign w_geom_err = (r_log2size < 6'd2)
                     || (32'(r_log2size) > RLEN)
                     || (32'(r_index) >= NB_REGION)
                     || ((r_base & w_size_mask) != '0);

    // L bit of the target byte in the freshly read cfg CSR
    assign w_lock_err  = csr_rd_data[w_shift + 5'd7];
    assign w_check_err = w_geom_err ? 2'd1 : (w_lock_err ? 2'd2 : 2'd0);

    assign w_new_byte = {r_lock, 2'b00, (r_log2size == 6'd2) ? 2'b10 : 2'b11, r_perm};
    assign w_cfg_dis  = r_old_cfg & ~(XLEN'(8'hFF) << w_shift);
    assign w_cfg_new  = w_cfg_dis | (XLEN'(w_new_byte) << w_shift);

    // NA4 writes the word address; NAPOT additionally fills the trailing
    // ones that encode the size. Truncation to XLEN drops nothing for
    // RLEN = XLEN + 2.
    assign w_addr_data = XLEN'(r_base[RLEN-1:2])
                       | ((r_log2size == 6'd2) ? '0 : XLEN'(w_napot_mask));

    always_ff @(posedge aclk) begin
        if (srst) begin
            r_state    <= IDLE;
            r_index    <= '0;
            r_base     <= '0;
            r_log2size <= '0;
            r_perm     <= '0;
            r_lock     <= 1'b0;
            r_old_cfg  <= '0;
            r_error    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && req_valid) begin
                r_index    <= req_index;
                r_base     <= req_base;
                r_log2size <= req_log2size;
                r_perm     <= req_perm;
                r_lock     <= req_lock;
            end
            if (r_state == CHECK) begin
                r_old_cfg <= csr_rd_data;
                r_error   <= w_check_err;
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        req_ready    = 1'b0;
        csr_rd_addr  = '0;
        csr_wr_valid = 1'b0;
        csr_wr_addr  = '0;
        csr_wr_data  = '0;
        rsp_valid    = 1'b0;
        rsp_error    = '0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_next = CHECK;
            end
            CHECK: begin
                csr_rd_addr = w_cfg_csr;
                w_next      = (w_check_err != 2'd0) ? RESP : WR_DIS;
            end
            WR_DIS: begin
                csr_wr_valid = 1'b1;
                csr_wr_addr  = w_cfg_csr;
                csr_wr_data  = w_cfg_dis;
                if (csr_wr_ready) w_next = WR_ADDR;
            end
            WR_ADDR: begin
                csr_wr_valid = 1'b1;
                csr_wr_addr  = w_addr_csr;
                csr_wr_data  = w_addr_data;
                if (csr_wr_ready) w_next = WR_CFG;
            end
            WR_CFG: begin
                csr_wr_valid = 1'b1;
                csr_wr_addr  = w_cfg_csr;
                csr_wr_data  = w_cfg_new;
                if (csr_wr_ready) w_next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_error = r_error;
                if (rsp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_friscv_pmp_encoder.sv
// -----------------------------------------------------------------------------
// tb_friscv_pmp_encoder
//
// Drives PMP programming requests into friscv_pmp_encoder and compares the
// CSR write sequence, completion code and latency against a reference model
// computed with plain 64-bit arithmetic. A small array stands in for the four
// pmpcfg CSRs; it answers the combinational read port and absorbs cfg writes.
// -----------------------------------------------------------------------------
module tb_friscv_pmp_encoder;

    localparam int XLEN      = 32;
    localparam int RLEN      = 34;
    localparam int NB_REGION = 16;

    logic            aclk = 1'b0;
    logic            srst = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [3:0]      req_index = '0;
    logic [RLEN-1:0] req_base = '0;
    logic [5:0]      req_log2size = '0;
    logic [2:0]      req_perm = '0;
    logic            req_lock = 1'b0;
    logic [11:0]     csr_rd_addr;
    logic [XLEN-1:0] csr_rd_data;
    logic            csr_wr_valid;
    logic            csr_wr_ready = 1'b0;
    logic [11:0]     csr_wr_addr;
    logic [XLEN-1:0] csr_wr_data;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [1:0]      rsp_error;

    friscv_pmp_encoder #(
        .XLEN      (XLEN),
        .RLEN      (RLEN),
        .NB_REGION (NB_REGION)
    ) dut (
        .aclk         (aclk),
        .srst         (srst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_index    (req_index),
        .req_base     (req_base),
        .req_log2size (req_log2size),
        .req_perm     (req_perm),
        .req_lock     (req_lock),
        .csr_rd_addr  (csr_rd_addr),
        .csr_rd_data  (csr_rd_data),
        .csr_wr_valid (csr_wr_valid),
        .csr_wr_ready (csr_wr_ready),
        .csr_wr_addr  (csr_wr_addr),
        .csr_wr_data  (csr_wr_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_error    (rsp_error)
    );

    always #5 aclk = ~aclk;

    logic [31:0] cfg_mem [4];

    always_comb begin
        csr_rd_data = 32'hDEAD_BEEF;
        if (csr_rd_addr[11:2] == 10'h0E8) csr_rd_data = cfg_mem[csr_rd_addr[1:0]];
    end

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic randomize_cfg();
        for (int w = 0; w < 4; w++) begin
            cfg_mem[w] = $urandom;
            for (int bi = 0; bi < 4; bi++)
                if ($urandom_range(0, 7) != 0) cfg_mem[w][8*bi+7] = 1'b0;
        end
    endtask

    // mode 0: always ready (latency checked); 1: random backpressure;
    // 2: 3 stall cycles per write and 4 on the response; 3: reset during WR_ADDR
    // Called and returns at 1 time unit after a rising edge.
    task automatic run_req(input int idx, input logic [63:0] base, input int l2,
                           input int perm, input int lock, input int mode);
        wr_t         exp_q[$];
        wr_t         got_q[$];
        wr_t         w;
        int          exp_err, got_err, b, k, cyc, first_rsp, wcnt, rcnt, hold;
        logic [63:0] old, mask, dis, av, bytev, nw;
        logic        done, aborted, p_wv, p_wr, p_rv, p_rr;
        logic [11:0] p_wa;
        logic [31:0] p_wd;
        logic [1:0]  p_re;

        // reference model
        b   = idx % 4;
        old = 64'(cfg_mem[idx / 4]);
        if (l2 < 2 || l2 > RLEN || idx >= NB_REGION) begin
            exp_err = 1;
        end else begin
            mask = (64'd1 << l2) - 64'd1;
            if ((base & mask) != 64'd0)              exp_err = 1;
            else if (((old >> (8*b + 7)) & 1) != 0)  exp_err = 2;
            else                                     exp_err = 0;
        end
        if (exp_err == 0) begin
            dis = old & ~(64'hFF << (8*b));
            av  = base >> 2;
            if (l2 >= 3) av = av | ((64'd1 << (l2 - 3)) - 64'd1);
            bytev = 64'(lock * 128 + ((l2 == 2) ? 2 : 3) * 8 + perm);
            nw    = dis | (bytev << (8*b));
            w.addr = 12'(32'h3A0 + idx / 4); w.data = dis[31:0]; exp_q.push_back(w);
            w.addr = 12'(32'h3B0 + idx);     w.data = av[31:0];  exp_q.push_back(w);
            w.addr = 12'(32'h3A0 + idx / 4); w.data = nw[31:0];  exp_q.push_back(w);
        end

        k = 0;
        while (!req_ready && k < 50) begin
            @(posedge aclk); #1; k++;
        end
        check("req_ready_idle", 64'(req_ready), 64'd1);
        req_valid    = 1'b1;
        req_index    = idx[3:0];
        req_base     = base[RLEN-1:0];
        req_log2size = l2[5:0];
        req_perm     = perm[2:0];
        req_lock     = lock[0];
        @(posedge aclk); #1;
        // scramble the fields to confirm they were captured on acceptance
        req_valid    = 1'b0;
        req_index    = 4'($urandom);
        req_base     = RLEN'({$urandom, $urandom});
        req_log2size = 6'($urandom);
        req_perm     = 3'($urandom);
        req_lock     = 1'($urandom);

        cyc = 1; done = 0; aborted = 0; first_rsp = -1;
        wcnt = 0; rcnt = 0; hold = 0; got_err = -1;
        p_wv = 0; p_wr = 0; p_rv = 0; p_rr = 0; p_wa = '0; p_wd = '0; p_re = '0;
        while (!done && cyc < 300) begin
            case (mode)
                1: begin
                    csr_wr_ready = ($urandom_range(0, 2) != 0);
                    rsp_ready    = ($urandom_range(0, 2) != 0);
                end
                2: begin
                    csr_wr_ready = csr_wr_valid && (wcnt >= 3);
                    rsp_ready    = rsp_valid && (rcnt >= 4);
                    if (csr_wr_valid && !csr_wr_ready) wcnt++;
                    if (rsp_valid && !rsp_ready) rcnt++;
                end
                default: begin
                    csr_wr_ready = 1'b1;
                    rsp_ready    = 1'b1;
                end
            endcase

            if (p_wv && !p_wr) begin
                check("wr_valid_hold", 64'(csr_wr_valid), 64'd1);
                check("wr_addr_hold", 64'(csr_wr_addr), 64'(p_wa));
                check("wr_data_hold", 64'(csr_wr_data), 64'(p_wd));
            end
            if (p_rv && !p_rr) begin
                check("rsp_valid_hold", 64'(rsp_valid), 64'd1);
                check("rsp_error_hold", 64'(rsp_error), 64'(p_re));
            end

            if (mode == 3 && csr_wr_valid && csr_wr_addr == 12'(32'h3B0 + idx)) begin
                csr_wr_ready = 1'b0;
                hold++;
                if (hold >= 3) begin
                    srst = 1'b1;
                    @(posedge aclk); #1;
                    srst = 1'b0;
                    check("rst_wr_valid", 64'(csr_wr_valid), 64'd0);
                    check("rst_req_ready", 64'(req_ready), 64'd1);
                    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
                    aborted = 1;
                    break;
                end
            end

            if (rsp_valid && first_rsp < 0) first_rsp = cyc;
            if (csr_wr_valid && csr_wr_ready) begin
                w.addr = csr_wr_addr; w.data = csr_wr_data;
                got_q.push_back(w);
                if (csr_wr_addr[11:2] == 10'h0E8) cfg_mem[csr_wr_addr[1:0]] = csr_wr_data;
                wcnt = 0;
            end
            if (rsp_valid && rsp_ready) begin
                got_err = int'(rsp_error);
                done = 1;
            end
            p_wv = csr_wr_valid; p_wr = csr_wr_ready; p_wa = csr_wr_addr; p_wd = csr_wr_data;
            p_rv = rsp_valid;    p_rr = rsp_ready;    p_re = rsp_error;
            @(posedge aclk); #1;
            cyc++;
        end
        csr_wr_ready = 1'b0;
        rsp_ready    = 1'b0;

        if (aborted) begin
            check("rst_wr_count", 64'(got_q.size()), 64'd1);
            if (got_q.size() >= 1 && exp_q.size() >= 1)
                check("rst_wr0_data", 64'(got_q[0].data), 64'(exp_q[0].data));
        end else begin
            check("rsp_seen", 64'(done), 64'd1);
            check("rsp_error", 64'(got_err), 64'(exp_err));
            check("wr_count", 64'(got_q.size()), 64'(exp_q.size()));
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                check("wr_addr", 64'(got_q[i].addr), 64'(exp_q[i].addr));
                check("wr_data", 64'(got_q[i].data), 64'(exp_q[i].data));
            end
            if (mode == 0)
                check("rsp_latency", 64'(first_rsp), (exp_err != 0) ? 64'd2 : 64'd5);
            check("post_rsp_valid", 64'(rsp_valid), 64'd0);
            check("post_req_ready", 64'(req_ready), 64'd1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          idx, l2;
        logic [63:0] base;

        for (int w = 0; w < 4; w++) cfg_mem[w] = '0;

        srst = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        check("reset_req_ready", 64'(req_ready), 64'd1);
        check("reset_wr_valid", 64'(csr_wr_valid), 64'd0);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_rsp_error", 64'(rsp_error), 64'd0);
        check("reset_wr_addr", 64'(csr_wr_addr), 64'd0);
        check("reset_wr_data", 64'(csr_wr_data), 64'd0);
        check("reset_rd_addr", 64'(csr_rd_addr), 64'd0);
        srst = 1'b0;
        @(posedge aclk); #1;

        // NAPOT 4 KiB at 0x8000_0000 on entry 5
        cfg_mem[1] = 32'h1122_3344;
        run_req(5, 64'h8000_0000, 12, 7, 0, 0);
        check("napot_cfg_final", 64'(cfg_mem[1]), 64'h1122_1F44);

        // NA4 on entry 0 with lock
        cfg_mem[0] = 32'h0;
        run_req(0, 64'h1000, 2, 1, 1, 0);
        check("na4_cfg_final", 64'(cfg_mem[0]), 64'h91);

        // geometry errors
        run_req(3, 64'h1100, 12, 7, 0, 0);
        run_req(3, 64'h1000, 1, 7, 0, 0);
        run_req(6, 64'h0, 35, 3, 0, 0);

        // locked entry, and geometry error taking priority over lock
        cfg_mem[0] = 32'h0080_0000;
        run_req(2, 64'h2000, 12, 3, 0, 0);
        run_req(2, 64'h2100, 12, 3, 0, 0);

        // full-range NAPOT and the smallest NAPOT
        cfg_mem[1] = 32'h0;
        run_req(4, 64'h0, 34, 5, 0, 0);
        run_req(7, 64'h3_FFFF_FFF8, 3, 2, 0, 0);

        // fixed backpressure on every write and on the response
        cfg_mem[2] = 32'h5566_7708;
        run_req(9, 64'h2_0000_0000, 20, 6, 1, 2);

        // reset while the address write is stalled, then a clean request
        cfg_mem[3] = 32'h0102_0304;
        run_req(13, 64'h4000, 14, 3, 0, 3);
        run_req(13, 64'h4000, 14, 3, 0, 0);

        for (int t = 0; t < 80; t++) begin
            randomize_cfg();
            idx  = $urandom_range(0, NB_REGION - 1);
            l2   = $urandom_range(0, 40);
            base = {$urandom, $urandom} & ((64'd1 << RLEN) - 64'd1);
            if (l2 <= RLEN && $urandom_range(0, 3) != 0)
                base = base & ~((64'd1 << l2) - 64'd1);
            run_req(idx, base, l2, $urandom_range(0, 7), $urandom_range(0, 1),
                    $urandom_range(0, 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
